fetch_stage: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline: owns the PC, reads the instruction ROM and

---
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
//   Owns the fetch PC, reads the instruction ROM combinationally and loads the
//   IF/ID pipeline register. Reset beats redirect, redirect beats stall.
// Parameters:
//   IMEM_DEPTH  instruction ROM depth in 32-bit words
//   IMEM_INIT   ROM image, word i at IMEM_INIT[i]
//   RESET_PC    PC loaded on reset
//   CNT_W       width of fetch_count
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   stall        hold PC, IF/ID and fetch_count
//   redirect     load redirect_pc and flush IF/ID
//   redirect_pc  redirect target
//   pc           current fetch PC
//   ifid_instr   IF/ID instruction (0 = NOP)
//   ifid_npc     IF/ID PC+4 of that instruction
//   ifid_valid   IF/ID holds a real instruction
//   fetch_count  saturating count of valid IF/ID loads
module fetch_stage #(
  parameter int unsigned                 IMEM_DEPTH = 128,
  parameter logic [IMEM_DEPTH-1:0][31:0] IMEM_INIT  = '0,
  parameter logic [31:0]                 RESET_PC   = 32'h0,
  parameter int unsigned                 CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_npc,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0] word_c;
  logic [31:0] pc_plus4_c;

  // ROM read; the full word index is range-checked so out-of-range fetches return a NOP
  always_comb begin
    word_c = 32'h0;
    if (pc[31:2] < 30'(IMEM_DEPTH)) begin
      word_c = IMEM_INIT[pc[AW+1:2]];
    end
  end

  // Sequential PC increment wraps modulo 2^32
  assign pc_plus4_c = pc + 32'd4;

  // PC, IF/ID register and fetch counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      ifid_instr  <= 32'h0;
      ifid_npc    <= 32'h0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      ifid_instr  <= 32'h0;
      ifid_npc    <= 32'h0;
      ifid_valid  <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_plus4_c;
      ifid_instr  <= word_c;
      ifid_npc    <= pc_plus4_c;
      ifid_valid  <= 1'b1;
      if (fetch_count != '1) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  function automatic logic [127:0][31:0] mk_rom();
    logic [127:0][31:0] r;
    for (int i = 0; i < 128; i++) r[i] = 32'hA000_0000 | 32'(i);
    r[0]  = 32'h2001_0005;
    r[1]  = 32'h2002_0003;
    r[2]  = 32'h0022_1820;
    r[16] = 32'h8C44_0010;
    return r;
  endfunction

  localparam logic [127:0][31:0] ROM = mk_rom();

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc, ifid_instr, ifid_npc;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic        reset_s, stall_s, redirect_s;
  logic [31:0] redirect_pc_s;
  logic [31:0] pc_s, ifid_instr_s, ifid_npc_s;
  logic        ifid_valid_s;
  logic [2:0]  fetch_count_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_stage #(.IMEM_DEPTH(128), .IMEM_INIT(ROM), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .fetch_count(fetch_count)
  );

  fetch_stage #(.IMEM_DEPTH(128), .IMEM_INIT(ROM), .RESET_PC(32'h0), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset_s), .stall(stall_s), .redirect(redirect_s),
    .redirect_pc(redirect_pc_s), .pc(pc_s), .ifid_instr(ifid_instr_s),
    .ifid_npc(ifid_npc_s), .ifid_valid(ifid_valid_s), .fetch_count(fetch_count_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_npc, input logic e_valid, input logic [15:0] e_cnt);
    chk({tag, ".pc"},    pc,                e_pc);
    chk({tag, ".instr"}, ifid_instr,        e_instr);
    chk({tag, ".npc"},   ifid_npc,          e_npc);
    chk({tag, ".valid"}, 32'(ifid_valid),   32'(e_valid));
    chk({tag, ".count"}, 32'(fetch_count),  32'(e_cnt));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    reset_s = 1'b0; stall_s = 1'b0; redirect_s = 1'b0; redirect_pc_s = 32'h0;

    // reset state
    step(); step();
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);

    // first fetches from the ROM image
    reset = 1'b1;
    step();
    chk_if("edge1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 16'd1);
    step();
    chk_if("edge2", 32'h8, 32'h2002_0003, 32'h8, 1'b1, 16'd2);

    // two stalled cycles at pc=8 hold everything
    stall = 1'b1;
    step();
    chk_if("stall1", 32'h8, 32'h2002_0003, 32'h8, 1'b1, 16'd2);
    step();
    chk_if("stall2", 32'h8, 32'h2002_0003, 32'h8, 1'b1, 16'd2);
    stall = 1'b0;
    step();
    chk_if("edge3", 32'hC, 32'h0022_1820, 32'hC, 1'b1, 16'd3);
    step();
    chk_if("edge4", 32'h10, 32'hA000_0003, 32'h10, 1'b1, 16'd4);

    // redirect wins over a simultaneous stall and flushes IF/ID
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    chk_if("redir", 32'h40, 32'h0, 32'h0, 1'b0, 16'd4);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_if("redir_tgt", 32'h44, 32'h8C44_0010, 32'h44, 1'b1, 16'd5);

    // back-to-back redirects, the second one out of ROM range
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk_if("b2b1", 32'h100, 32'h0, 32'h0, 1'b0, 16'd5);
    redirect_pc = 32'h200;
    step();
    chk_if("b2b2", 32'h200, 32'h0, 32'h0, 1'b0, 16'd5);
    redirect = 1'b0;
    step();
    chk_if("oob", 32'h204, 32'h0, 32'h204, 1'b1, 16'd6);

    // PC wraps from FFFF_FFFC to 0
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_load.pc", pc, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk_if("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 16'd7);
    step();
    chk_if("after_wrap", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 16'd8);

    // low PC bits are ignored by the ROM read
    redirect = 1'b1; redirect_pc = 32'h6;
    step();
    redirect = 1'b0;
    step();
    chk_if("unaligned", 32'hA, 32'h2002_0003, 32'hA, 1'b1, 16'd9);

    // reset mid-run at pc=0x1C, beating a simultaneous redirect
    redirect = 1'b1; redirect_pc = 32'h1C;
    step();
    chk("at_1c.pc", pc, 32'h1C);
    reset = 1'b0; redirect_pc = 32'h80;
    step();
    chk_if("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    reset = 1'b1; redirect = 1'b0;
    step();
    chk_if("post_reset", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 16'd1);

    // 3-bit counter saturates at 7 over 10 unstalled cycles
    chk("sat_reset", 32'(fetch_count_s), 32'd0);
    reset_s = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("sat_6", 32'(fetch_count_s), 32'd6);
    step();
    chk("sat_7", 32'(fetch_count_s), 32'd7);
    for (int i = 0; i < 3; i++) step();
    chk("sat_10", 32'(fetch_count_s), 32'd7);
    chk("sat_pc", pc_s, 32'd40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
